// File: rtl/irq_ctrl_if.sv
// Bundle of request, CPU handshake and mask signals around irq_ctrl.
// slave = controller side, master = CPU / source side.
interface irq_ctrl_if #(
  parameter int unsigned NUM_SRC = 4
);
  logic [NUM_SRC-1:0] irq_in;
  logic [NUM_SRC-1:0] dev_ack;
  logic               cpu_irq;
  logic               cpu_ack;
  logic               iret;
  logic [15:0]        vector;
  logic [3:0]         cur_src;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_din;
  logic [NUM_SRC-1:0] mask;

  modport slave (
    input  irq_in, cpu_ack, iret, mask_we, mask_din,
    output dev_ack, cpu_irq, vector, cur_src, mask
  );

  modport master (
    output irq_in, cpu_ack, iret, mask_we, mask_din,
    input  dev_ack, cpu_irq, vector, cur_src, mask
  );
endinterface

// File: rtl/irq_ctrl.sv
// Masked, prioritised interrupt controller with a single in-service slot.
// Define IRQ_CTRL_ROUND_ROBIN_EN for rotating priority instead of lowest-index-wins.
//
// state     | meaning
// S_IDLE    | no interrupt outstanding, arbitrating pending requests
// S_PEND    | grant registered, cpu_irq high, waiting for cpu_ack
// S_SERVICE | CPU running the ISR, waiting for iret
module irq_ctrl #(
  parameter int unsigned        NUM_SRC    = 4,
  parameter logic [15:0]        VEC_BASE   = 16'h0100,
  parameter logic [15:0]        VEC_STRIDE = 16'h0010,
  parameter logic [NUM_SRC-1:0] MASK_RESET = '1
) (
  input logic       clk,
  input logic       rst_n,
  irq_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PEND    = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

  logic [1:0]         state_q,   state_d;
  logic [3:0]         cur_src_q, cur_src_d;
  logic [15:0]        vector_q,  vector_d;
  logic               cpu_irq_q, cpu_irq_d;
  logic [NUM_SRC-1:0] dev_ack_q, dev_ack_d;
  logic [NUM_SRC-1:0] mask_q,    mask_d;

  logic [15:0] pending_w;
  logic        win_found;
  logic [3:0]  win_idx;
  logic [3:0]  cand;

`ifdef IRQ_CTRL_ROUND_ROBIN_EN
  logic [3:0] ptr_q, ptr_d;
  logic [4:0] sum;
`endif

  // Zero-extended so a 4-bit index never exceeds the vector width.
  assign pending_w = 16'(bus.irq_in & mask_q);

  always_comb begin
    win_found = 1'b0;
    win_idx   = 4'd0;
    cand      = 4'd0;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
    sum       = 5'd0;
`endif
    for (int i = 0; i < NUM_SRC; i++) begin
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
      sum = 5'(ptr_q) + 5'(i);
      if (sum >= 5'(NUM_SRC)) begin
        sum = sum - 5'(NUM_SRC);
      end
      cand = sum[3:0];
`else
      cand = 4'(i);
`endif
      if (!win_found && pending_w[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_src_d = cur_src_q;
    vector_d  = vector_q;
    cpu_irq_d = cpu_irq_q;
    dev_ack_d = '0;
    mask_d    = bus.mask_we ? bus.mask_din : mask_q;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d   = S_PEND;
          cur_src_d = win_idx;
          vector_d  = VEC_BASE + VEC_STRIDE * {12'h000, win_idx};
          cpu_irq_d = 1'b1;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
          ptr_d     = (win_idx == 4'(NUM_SRC - 1)) ? 4'd0 : win_idx + 4'd1;
`endif
        end
      end
      S_PEND: begin
        // Grant is locked in: the source may drop or be masked without effect.
        if (bus.cpu_ack) begin
          state_d   = S_SERVICE;
          cpu_irq_d = 1'b0;
          dev_ack_d = {{(NUM_SRC-1){1'b0}}, 1'b1} << cur_src_q;
        end
      end
      S_SERVICE: begin
        if (bus.iret) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        cpu_irq_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cur_src_q <= 4'd0;
      vector_q  <= 16'h0000;
      cpu_irq_q <= 1'b0;
      dev_ack_q <= '0;
      mask_q    <= MASK_RESET;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
      ptr_q     <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      cur_src_q <= cur_src_d;
      vector_q  <= vector_d;
      cpu_irq_q <= cpu_irq_d;
      dev_ack_q <= dev_ack_d;
      mask_q    <= mask_d;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign bus.cpu_irq = cpu_irq_q;
  assign bus.dev_ack = dev_ack_q;
  assign bus.vector  = vector_q;
  assign bus.cur_src = cur_src_q;
  assign bus.mask    = mask_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed scenarios plus randomized traffic checked against a cycle-level
// reference model of the interrupt controller (4 sources, default vectors).
module tb_irq_ctrl;
  localparam int N      = 4;
  localparam int BASE   = 'h0100;
  localparam int STRIDE = 'h0010;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  irq_ctrl_if #(.NUM_SRC(N)) bus ();

  irq_ctrl #(.NUM_SRC(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    rst_n        = 1'b0;
    bus.irq_in   = '0;
    bus.cpu_ack  = 1'b0;
    bus.iret     = 1'b0;
    bus.mask_we  = 1'b0;
    bus.mask_din = '0;
    tick();
    rst_n = 1'b1;
  endtask

  // Reference model: spec-level view of the single in-service slot.
  int m_phase;  // 0 idle, 1 waiting for CPU accept, 2 in service
  int m_cur, m_vec, m_mask, m_ptr, m_dev;

  function automatic int pick(input int p, input int start);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (start + k) % N;
      if (p[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cur = 0; m_vec = 0; m_mask = 'hF; m_ptr = 0; m_dev = 0;
  endtask

  task automatic model_step(input int irq, input bit ack, input bit ir, input bit we, input int din);
    int w;
    m_dev = 0;
    if (m_phase == 0) begin
      w = pick(irq & m_mask, m_ptr);
      if (w >= 0) begin
        m_cur   = w;
        m_vec   = (BASE + w * STRIDE) & 'hFFFF;
        m_phase = 1;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
        m_ptr   = (w + 1) % N;
`endif
      end
    end else if (m_phase == 1) begin
      if (ack) begin
        m_dev   = 1 << m_cur;
        m_phase = 2;
      end
    end else if (ir) begin
      m_phase = 0;
    end
    if (we) m_mask = din;
  endtask

  initial begin
    int exp_rr [4];
    reset_dut();
    rst_n = 1'b0;
    tick();
    chk("rst_cpu_irq", 32'(bus.cpu_irq), 0);
    chk("rst_vector",  32'(bus.vector), 0);
    chk("rst_cur_src", 32'(bus.cur_src), 0);
    chk("rst_mask",    32'(bus.mask), 'hF);
    chk("rst_dev_ack", 32'(bus.dev_ack), 0);
    rst_n = 1'b1;

    // Single source
    reset_dut();
    bus.irq_in = 4'b0100;
    tick();
    chk("single_cpu_irq", 32'(bus.cpu_irq), 1);
    chk("single_vector",  32'(bus.vector), 'h0120);
    chk("single_cur_src", 32'(bus.cur_src), 2);
    chk("single_no_ack",  32'(bus.dev_ack), 0);
    bus.cpu_ack = 1'b1;
    tick();
    bus.cpu_ack = 1'b0;
    chk("single_dev_ack",     32'(bus.dev_ack), 'b0100);
    chk("single_irq_dropped", 32'(bus.cpu_irq), 0);
    tick();
    chk("single_ack_one_cycle", 32'(bus.dev_ack), 0);
    bus.irq_in = '0;
    bus.iret   = 1'b1;
    tick();
    bus.iret = 1'b0;
    tick();
    chk("single_idle_quiet", 32'(bus.cpu_irq), 0);

    // cpu_ack while idle is ignored
    bus.cpu_ack = 1'b1;
    tick();
    bus.cpu_ack = 1'b0;
    chk("idle_ack_no_dev_ack", 32'(bus.dev_ack), 0);
    tick();
    chk("idle_ack_no_dev_ack2", 32'(bus.dev_ack), 0);

    // Simultaneous requests, no nesting, back-to-back after iret
    reset_dut();
    bus.irq_in = 4'b1010;
    tick();
    chk("simul_cur_src", 32'(bus.cur_src), 1);
    chk("simul_vector",  32'(bus.vector), 'h0110);
    bus.cpu_ack = 1'b1;
    tick();
    bus.cpu_ack = 1'b0;
    bus.irq_in  = 4'b1000;
    chk("simul_dev_ack", 32'(bus.dev_ack), 'b0010);
    tick();
    chk("service_no_nesting", 32'(bus.cpu_irq), 0);
    bus.iret = 1'b1;
    tick();
    bus.iret = 1'b0;
    chk("iret_plus1_quiet", 32'(bus.cpu_irq), 0);
    tick();
    chk("iret_plus2_irq",     32'(bus.cpu_irq), 1);
    chk("iret_plus2_vector",  32'(bus.vector), 'h0130);
    chk("iret_plus2_cur_src", 32'(bus.cur_src), 3);

    // Priority scheme with a held pair of requests
    exp_rr = '{0, 0, 0, 0};
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
    exp_rr = '{0, 1, 0, 1};
`endif
    reset_dut();
    bus.irq_in = 4'b0011;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk($sformatf("prio_grant%0d", g), 32'(bus.cur_src), 32'(exp_rr[g]));
      bus.cpu_ack = 1'b1;
      tick();
      bus.cpu_ack = 1'b0;
      bus.iret    = 1'b1;
      tick();
      bus.iret = 1'b0;
    end

    // Masking
    reset_dut();
    bus.mask_we  = 1'b1;
    bus.mask_din = 4'b1110;
    tick();
    bus.mask_we = 1'b0;
    chk("mask_written", 32'(bus.mask), 'b1110);
    bus.irq_in = 4'b0001;
    tick();
    chk("masked_quiet", 32'(bus.cpu_irq), 0);
    tick();
    chk("masked_quiet2", 32'(bus.cpu_irq), 0);
    bus.mask_we  = 1'b1;
    bus.mask_din = 4'b1111;
    tick();
    bus.mask_we = 1'b0;
    chk("unmask_same_cycle", 32'(bus.cpu_irq), 0);
    tick();
    chk("unmask_irq",    32'(bus.cpu_irq), 1);
    chk("unmask_vector", 32'(bus.vector), 'h0100);

    // iret coincident with a mask write
    reset_dut();
    bus.irq_in = 4'b0011;
    tick();
    bus.cpu_ack = 1'b1;
    tick();
    bus.cpu_ack  = 1'b0;
    bus.iret     = 1'b1;
    bus.mask_we  = 1'b1;
    bus.mask_din = 4'b0010;
    tick();
    bus.iret    = 1'b0;
    bus.mask_we = 1'b0;
    chk("iret_mask_mask", 32'(bus.mask), 'b0010);
    tick();
    chk("iret_mask_cur_src", 32'(bus.cur_src), 1);
    chk("iret_mask_vector",  32'(bus.vector), 'h0110);

    // Reset while PEND
    reset_dut();
    bus.mask_we  = 1'b1;
    bus.mask_din = 4'b0011;
    tick();
    bus.mask_we = 1'b0;
    bus.irq_in  = 4'b0010;
    tick();
    chk("pend_before_rst", 32'(bus.cpu_irq), 1);
    rst_n = 1'b0;
    tick();
    chk("rst_pend_cpu_irq", 32'(bus.cpu_irq), 0);
    chk("rst_pend_vector",  32'(bus.vector), 0);
    chk("rst_pend_mask",    32'(bus.mask), 'hF);
    chk("rst_pend_dev_ack", 32'(bus.dev_ack), 0);
    rst_n = 1'b1;
    tick();
    chk("regrant_cpu_irq", 32'(bus.cpu_irq), 1);
    chk("regrant_cur_src", 32'(bus.cur_src), 1);
    chk("regrant_vector",  32'(bus.vector), 'h0110);

    // Randomized traffic against the reference model
    reset_dut();
    model_reset();
    for (int c = 0; c < 300; c++) begin
      bus.irq_in   = 4'($urandom_range(0, 15));
      bus.cpu_ack  = ($urandom_range(0, 2) == 0);
      bus.iret     = ($urandom_range(0, 2) == 0);
      bus.mask_we  = ($urandom_range(0, 7) == 0);
      bus.mask_din = 4'($urandom_range(0, 15));
      model_step(int'(bus.irq_in), bus.cpu_ack, bus.iret, bus.mask_we, int'(bus.mask_din));
      tick();
      chk("rand_cpu_irq", 32'(bus.cpu_irq), 32'(m_phase == 1));
      chk("rand_dev_ack", 32'(bus.dev_ack), 32'(m_dev));
      chk("rand_vector",  32'(bus.vector), 32'(m_vec));
      chk("rand_cur_src", 32'(bus.cur_src), 32'(m_cur));
      chk("rand_mask",    32'(bus.mask), 32'(m_mask));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
